twos_complement_seq: RTL and testbench

//  Parametrised multi-cycle two's-complement unit: negates (or takes |x| of) a WIDTH-bit operand.

---
 rtl/twos_complement_seq.sv | 112 +++++++++++
 tb/tb_twos_complement_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_complement_seq.sv
// twos_complement_seq
//   Multi-cycle two's-complement unit. Negates a WIDTH-bit signed operand, or
//   takes its absolute value, rippling the +1 carry through one CHUNK-bit slice
//   per clock. Latency is fixed at NCHUNK cycles from the accepting edge to the
//   ready pulse, whatever the operand or mode.
//
//   Ports
//     clk     in   1      system clock, rising edge
//     rst     in   1      asynchronous active-high reset
//     start   in   1      request, sampled only while busy is low
//     mode    in   1      0 = negate (-A), 1 = absolute value (|A|)
//     A       in   WIDTH  signed operand, sampled on the accepting edge
//     result  out  WIDTH  result, valid from ready until the next accepted start
//     busy    out  1      operation in progress
//     ready   out  1      one-cycle pulse, result/ovf valid
//     ovf     out  1      true result not representable (A == MIN)
//
//   Build option
//     TWOS_SAT_EN  when defined, an overflowing result is replaced by MAX on
//                  the final slice edge; otherwise the wrapped value MIN is kept.
//
//   States
//     S_IDLE | waiting for start
//     S_RUN  | rippling one slice per clock
//     S_DONE | ready pulse; a start here goes straight back to S_RUN
module twos_complement_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             ready,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef TWOS_SAT_EN
  localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] result_r;
  logic             ovf_r;

  logic             keep_op;
  logic [CHUNK:0]   slice_sum;

  // Abs of a non-negative operand passes it through unchanged (carry 0), but
  // still walks every slice so the latency never depends on the data.
  assign keep_op   = mode && !A[WIDTH-1];
  assign slice_sum = {1'b0, op[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op    <= keep_op ? A : ~A;
            carry <= !keep_op;
            idx   <= '0;
            ovf_r <= (A == MIN_VAL) && (!mode || A[WIDTH-1]);
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          result_r[idx*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          carry <= slice_sum[CHUNK];
          if (idx == LAST_IDX) begin
            state <= S_DONE;
`ifdef TWOS_SAT_EN
            // Overrides the last slice write above when the result overflowed.
            if (ovf_r) result_r <= MAX_VAL;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign ready  = (state == S_DONE);
  assign result = result_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_twos_complement_seq.sv
module tb_twos_complement_seq;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] result;
  logic        busy, ready, ovf;

  logic        start8 = 1'b0;
  logic        mode8 = 1'b0;
  logic [7:0]  A8 = '0;
  logic [7:0]  result8;
  logic        busy8, ready8, ovf8;

  int checks = 0;
  int errors = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  twos_complement_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A),
    .result(result), .busy(busy), .ready(ready), .ovf(ovf)
  );

  twos_complement_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .A(A8),
    .result(result8), .busy(busy8), .ready(ready8), .ovf(ovf8)
  );

  function automatic exp_t model16(input logic m, input logic [15:0] a);
    exp_t e;
    e.ovf = (a == 16'h8000);
    e.res = (m && !a[15]) ? a : (16'h0000 - a);
`ifdef TWOS_SAT_EN
    if (e.ovf) e.res = 16'h7FFF;
`endif
    return e;
  endfunction

  function automatic exp_t model8(input logic m, input logic [7:0] a);
    exp_t e;
    logic [7:0] r;
    e.ovf = (a == 8'h80);
    r = (m && !a[7]) ? a : (8'h00 - a);
`ifdef TWOS_SAT_EN
    if (e.ovf) r = 8'h7F;
`endif
    e.res = {8'h00, r};
    return e;
  endfunction

  // Called #1 after an edge with the DUT idle or in its ready cycle.
  task automatic issue16(input logic m, input logic [15:0] a);
    start = 1'b1; mode = m; A = a;
    q16.push_back(model16(m, a));
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom_range(0, 16'hFFFF);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  task automatic wait16(input string name, input int lat);
    int cnt = 0;
    exp_t e;
    while (ready !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, cnt, lat);
    end
    if (q16.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_queue: got empty want entry", name);
    end else begin
      e = q16.pop_front();
      checks++;
      if (result !== e.res || ovf !== e.ovf || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s: got result=%h ovf=%b busy=%b want result=%h ovf=%b busy=0",
                 name, result, ovf, busy, e.res, e.ovf);
      end
    end
  endtask

  task automatic check_ready_drops(input string name);
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got ready=%b busy=%b want 0 0", name, ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (result !== 16'h0 || busy !== 1'b0 || ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: got result=%h busy=%b ready=%b ovf=%b want 0 0 0 0",
               result, busy, ready, ovf);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_negate;
    issue16(1'b0, 16'h0001); wait16("neg_0001", 4); check_ready_drops("neg_0001");
    // Previous result is FFFF; a zero operand clears one slice per edge as the carry ripples.
    issue16(1'b0, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== (16'hFFFF << (4 * k))) begin
        errors++;
        $display("FAIL ripple_slice%0d: got %h want %h", k, result, 16'hFFFF << (4 * k));
      end
    end
    wait16("neg_0000", 1);
    issue16(1'b0, 16'h8000); wait16("neg_8000", 4);
    issue16(1'b0, 16'h1234); wait16("neg_1234", 4); check_ready_drops("neg_1234");
  endtask

  task automatic test_abs;
    issue16(1'b1, 16'hFF9C); wait16("abs_ff9c", 4);
    issue16(1'b1, 16'h0064); wait16("abs_0064", 4);
    issue16(1'b1, 16'h8000); wait16("abs_8000", 4);
    issue16(1'b1, 16'h7FFF); wait16("abs_7fff", 4); check_ready_drops("abs_7fff");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    start = 1'b1; mode = 1'b0; A = 16'h0003;
    q16.push_back(model16(1'b0, 16'h0003));
    @(posedge clk); #1;
    // start stays high and operands wander while busy; all of it must be ignored.
    for (int k = 0; k < 3; k++) begin
      mode = ~mode;
      A = $urandom_range(0, 16'hFFFF);
      @(posedge clk); #1;
    end
    mode = 1'b0; A = 16'h0002;
    q16.push_back(model16(1'b0, 16'h0002));
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ready: got %b want 1", ready);
    end
    e = q16.pop_front();
    checks++;
    if (result !== e.res || ovf !== e.ovf) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b want %h/%b", result, ovf, e.res, e.ovf);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: got busy=%b ready=%b want 1 0", busy, ready);
    end
    wait16("b2b_second", 4);
    check_ready_drops("b2b_second");
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    issue16(1'b0, 16'h1234);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    void'(q16.pop_back());
    #1;
    checks++;
    if (result !== 16'h0 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got result=%h busy=%b ready=%b want 0 0 0", result, busy, ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_no_ready: got %0d ready cycles want 0", seen);
    end
    issue16(1'b0, 16'h0005); wait16("after_reset", 4);
  endtask

  task automatic test_width8;
    logic [7:0] ops [3] = '{8'h01, 8'h00, 8'h80};
    exp_t e;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1; mode8 = 1'b0; A8 = ops[i];
      q8.push_back(model8(1'b0, ops[i]));
      @(posedge clk); #1;
      start8 = 1'b0;
      cnt = 0;
      while (ready8 !== 1'b1 && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      e = q8.pop_front();
      checks++;
      if (cnt != 1 || {8'h00, result8} !== e.res || ovf8 !== e.ovf) begin
        errors++;
        $display("FAIL w8_%h: got lat=%0d result=%h ovf=%b want lat=1 result=%h ovf=%b",
                 ops[i], cnt, result8, ovf8, e.res[7:0], e.ovf);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_negate;
    test_abs;
    test_back_to_back;
    test_reset_mid_run;
    test_width8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
